lsu: RTL and testbench

Load/store unit for the CPU's memory stage, directly downstream of the ALU. It takes the ALU result `R` as the effective address, together with the store data and the decoded access type. It runs a single request/acknowledge transaction on the data-memory port and returns sign- or zero-extended load data to the register-file writeback. Sub-word accesses are byte-lane steered (little-endian), and misaligned accesses are rejected without touching memory.

---
 rtl/lsu_if.sv | 51 +++++
 rtl/lsu.sv | 135 +++++++++++++
 tb/tb_lsu.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// lsu_if: request, data-memory and writeback bundle of the load/store unit.
//   request  : req_valid/req_ready handshake with req_store, req_size, req_unsigned,
//              addr (effective address), wdata (store data), req_rd (load dest)
//   memory   : mem_req/mem_ack handshake with mem_we, mem_addr (word aligned),
//              mem_be, mem_wdata (lane replicated), mem_rdata
//   writeback: wb_valid, wb_rd, wb_data, plus done / misaligned completion pulses
// modport master: the LSU itself; modport slave: the surrounding pipeline/memory.
`ifndef W_CPU
`define W_CPU 32
`endif

interface lsu_if #(
  parameter int W = `W_CPU
);
  logic         req_valid;
  logic         req_ready;
  logic         req_store;
  logic [1:0]   req_size;
  logic         req_unsigned;
  logic [W-1:0] addr;
  logic [W-1:0] wdata;
  logic [4:0]   req_rd;

  logic         mem_req;
  logic         mem_we;
  logic [W-1:0] mem_addr;
  logic [3:0]   mem_be;
  logic [W-1:0] mem_wdata;
  logic         mem_ack;
  logic [W-1:0] mem_rdata;

  logic         wb_valid;
  logic [4:0]   wb_rd;
  logic [W-1:0] wb_data;
  logic         done;
  logic         misaligned;

  modport master (
    input  req_valid, req_store, req_size, req_unsigned, addr, wdata, req_rd,
    input  mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output wb_valid, wb_rd, wb_data, done, misaligned
  );

  modport slave (
    output req_valid, req_store, req_size, req_unsigned, addr, wdata, req_rd,
    output mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  wb_valid, wb_rd, wb_data, done, misaligned
  );
endinterface

// File: rtl/lsu.sv
// lsu: load/store unit of the memory stage.
// Accepts one access in IDLE (req_valid & req_ready), issues a single
// mem_req/mem_ack transaction with little-endian byte-lane steering, and
// returns sign/zero-extended load data on wb_*. Misaligned half/word
// accesses complete immediately with a misaligned pulse and no memory access.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - lsu_if.master (request, data-memory and writeback signals)
`ifndef W_CPU
`define W_CPU 32
`endif

module lsu #(
  parameter int W = `W_CPU
) (
  input  logic   clk,
  input  logic   rst,
  lsu_if.master  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t       state;
  logic         store_q;
  logic [1:0]   size_q;
  logic         uns_q;
  logic [4:0]   rd_q;
  logic [1:0]   off_q;

  logic         is_half;
  logic         is_word;
  logic         mis;
  logic [3:0]   be_n;
  logic [W-1:0] wdata_n;
  logic [15:0]  lane;
  logic [W-1:0] ld_data;

  assign bus.req_ready = (state == IDLE);

  // Request decode: alignment check and store lane steering (size 3 acts as word).
  always_comb begin
    is_half = (bus.req_size == 2'd1);
    is_word = bus.req_size[1];
    mis     = (is_half & bus.addr[0]) | (is_word & (bus.addr[1:0] != 2'b00));
    be_n    = 4'b1111;
    wdata_n = bus.wdata;
    if (bus.req_size == 2'd0) begin
      be_n    = 4'b0001 << bus.addr[1:0];
      wdata_n = {4{bus.wdata[7:0]}};
    end else if (is_half) begin
      be_n    = 4'b0011 << bus.addr[1:0];
      wdata_n = {2{bus.wdata[15:0]}};
    end
  end

  // Load extraction: shift the addressed lane down to bit 0, then extend.
  always_comb begin
    lane    = 16'(bus.mem_rdata >> {off_q, 3'b000});
    ld_data = bus.mem_rdata;
    if (size_q == 2'd0) begin
      ld_data = {{(W-8){~uns_q & lane[7]}}, lane[7:0]};
    end else if (size_q == 2'd1) begin
      ld_data = {{(W-16){~uns_q & lane[15]}}, lane[15:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      store_q        <= 1'b0;
      size_q         <= '0;
      uns_q          <= 1'b0;
      rd_q           <= '0;
      off_q          <= '0;
      bus.mem_req    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_be     <= '0;
      bus.mem_wdata  <= '0;
      bus.wb_valid   <= 1'b0;
      bus.wb_rd      <= '0;
      bus.wb_data    <= '0;
      bus.done       <= 1'b0;
      bus.misaligned <= 1'b0;
    end else begin
      bus.wb_valid   <= 1'b0;
      bus.done       <= 1'b0;
      bus.misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            store_q <= bus.req_store;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            rd_q    <= bus.req_rd;
            off_q   <= bus.addr[1:0];
            if (mis) begin
              state          <= DONE;
              bus.done       <= 1'b1;
              bus.misaligned <= 1'b1;
            end else begin
              state         <= ISSUE;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= bus.req_store;
              bus.mem_addr  <= {bus.addr[W-1:2], 2'b00};
              bus.mem_be    <= bus.req_store ? be_n : 4'b1111;
              bus.mem_wdata <= wdata_n;
            end
          end
        end
        ISSUE: begin
          if (bus.mem_ack) begin
            state       <= DONE;
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            bus.done    <= 1'b1;
            if (!store_q) begin
              bus.wb_valid <= 1'b1;
              bus.wb_rd    <= rd_q;
              bus.wb_data  <= ld_data;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed test of the load/store unit against a cycle-indexed
// expectation table built from the access rules and a small memory map.
module tb_lsu;
  localparam int NE = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_if #(.W(32)) bus();
  lsu #(.W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int e = 0;                 // number of rising edges so far
  always @(posedge clk) e <= e + 1;

  int checks = 0;
  int errors = 0;
  int free_e = 0;            // earliest edge count at which the unit is ready

  // Expected outputs for the cycle following edge number e.
  bit          x_ready[NE];
  bit          x_mreq[NE];
  bit          x_we[NE];
  bit          x_wbv[NE];
  bit          x_done[NE];
  bit          x_mis[NE];
  logic [31:0] x_addr[NE];
  logic [31:0] x_wdat[NE];
  logic [31:0] x_wbd[NE];
  logic [3:0]  x_be[NE];
  logic [4:0]  x_rd[NE];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (edge %0d): got %h, expected %h", name, e, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    case (w)
      32'h0000_1000: return 32'h80FF_1234;
      32'h0000_1004: return 32'hDEAD_BEEF;
      32'h0000_1008: return 32'h89AB_F00D;
      32'h0000_100C: return 32'h7F00_8001;
      default:       return w ^ 32'hC3A5_0F96;
    endcase
  endfunction

  function automatic bit model_mis(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd1) return a[0];
    if (sz >= 2'd2) return (a[1:0] != 2'b00);
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_be(input logic st, input logic [1:0] sz, input logic [31:0] a);
    if (!st || sz >= 2'd2) return 4'hF;
    if (sz == 2'd0) return 4'(1 << a[1:0]);
    return 4'(3 << a[1:0]);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return {4{wd[7:0]}};
    if (sz == 2'd1) return {2{wd[15:0]}};
    return wd;
  endfunction

  function automatic logic [31:0] ld_ext(input logic [31:0] word, input logic [1:0] off,
                                         input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    v = word >> (8 * off);
    if (sz == 2'd0) begin
      v = v & 32'h0000_00FF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = v & 32'h0000_FFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  // Per-cycle comparison against the expectation table.
  always @(negedge clk) begin : compare
    int i;
    i = e;
    if (i > 0 && i < NE) begin
      chk("req_ready", 32'(bus.req_ready), 32'(x_ready[i]));
      chk("mem_req", 32'(bus.mem_req), 32'(x_mreq[i]));
      chk("mem_we", 32'(bus.mem_we), 32'(x_we[i]));
      chk("wb_valid", 32'(bus.wb_valid), 32'(x_wbv[i]));
      chk("done", 32'(bus.done), 32'(x_done[i]));
      chk("misaligned", 32'(bus.misaligned), 32'(x_mis[i]));
      if (x_mreq[i]) begin
        chk("mem_addr", bus.mem_addr, x_addr[i]);
        chk("mem_be", 32'(bus.mem_be), 32'(x_be[i]));
        if (x_we[i]) chk("mem_wdata", bus.mem_wdata, x_wdat[i]);
      end
      if (x_wbv[i]) begin
        chk("wb_rd", 32'(bus.wb_rd), 32'(x_rd[i]));
        chk("wb_data", bus.wb_data, x_wbd[i]);
      end
    end
  end

  task automatic check_reset();
    chk("rst req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst mem_addr", bus.mem_addr, 32'd0);
    chk("rst mem_be", 32'(bus.mem_be), 32'd0);
    chk("rst mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst wb_rd", 32'(bus.wb_rd), 32'd0);
    chk("rst wb_data", bus.wb_data, 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst misaligned", 32'(bus.misaligned), 32'd0);
  endtask

  // One access: w = memory wait cycles before ack, hold = cycles ack stays high,
  // keep = leave req_valid asserted afterwards (back-to-back streams).
  task automatic access(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a_in, input logic [31:0] wd, input logic [4:0] rd,
                        input int w, input int hold, input bit keep);
    int a;
    bit m;
    logic [31:0] word;
    while (e < free_e) @(negedge clk);
    a    = e + 1;
    m    = model_mis(sz, a_in);
    word = mem_word(a_in);
    if (m) begin
      x_ready[a] = 1'b0;
      x_done[a]  = 1'b1;
      x_mis[a]   = 1'b1;
      free_e     = a + 1;
    end else begin
      for (int i = a; i <= a + w; i++) begin
        x_mreq[i] = 1'b1;
        x_we[i]   = st;
        x_addr[i] = {a_in[31:2], 2'b00};
        x_be[i]   = model_be(st, sz, a_in);
        x_wdat[i] = model_wdata(sz, wd);
      end
      for (int i = a; i <= a + w + 1; i++) x_ready[i] = 1'b0;
      x_done[a+w+1] = 1'b1;
      if (!st) begin
        x_wbv[a+w+1] = 1'b1;
        x_rd[a+w+1]  = rd;
        x_wbd[a+w+1] = ld_ext(word, a_in[1:0], sz, uns);
      end
      free_e = a + w + 2;
    end
    bus.req_valid    = 1'b1;
    bus.req_store    = st;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.addr         = a_in;
    bus.wdata        = wd;
    bus.req_rd       = rd;
    @(negedge clk);
    if (!keep) bus.req_valid = 1'b0;
    if (!m) begin
      while (e < a + w) @(negedge clk);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = word;
      repeat (hold) @(negedge clk);
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h5A5A_5A5A;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int a;
    logic [31:0] v;
    for (int i = 0; i < NE; i++) x_ready[i] = 1'b1;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.addr = '0; bus.wdata = '0; bus.req_rd = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;

    // Pin the model against hand-computed values.
    v = 32'h80FF_1234;
    chk("pin byte signed", ld_ext(v, 2'd3, 2'd0, 1'b0), 32'hFFFF_FF80);
    chk("pin byte unsigned", ld_ext(v, 2'd3, 2'd0, 1'b1), 32'h0000_0080);
    chk("pin half signed", ld_ext(v, 2'd2, 2'd1, 1'b0), 32'hFFFF_80FF);
    chk("pin mem word", mem_word(32'h0000_1007), 32'hDEAD_BEEF);
    v = 32'h0000_00AB;
    chk("pin store wdata", model_wdata(2'd0, v), 32'hABAB_ABAB);
    chk("pin store be", 32'(model_be(1'b1, 2'd0, 32'h0000_2001)), 32'h0000_0002);
    chk("pin mis half", 32'(model_mis(2'd1, 32'h0000_3001)), 32'd1);
    chk("pin mis word", 32'(model_mis(2'd2, 32'h0000_3002)), 32'd1);

    repeat (2) @(negedge clk);
    check_reset();
    rst = 1'b0;
    free_e = e;

    // Word load with two wait cycles: mem_req high for three cycles.
    access(1'b0, 2'd2, 1'b0, 32'h0000_1004, 32'h0, 5'd7, 2, 1, 1'b0);
    // Sub-word loads, signed and unsigned, several lanes.
    access(1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0, 5'd1, 0, 1, 1'b0);
    access(1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0, 5'd2, 1, 1, 1'b0);
    access(1'b0, 2'd1, 1'b0, 32'h0000_1002, 32'h0, 5'd3, 0, 1, 1'b0);
    access(1'b0, 2'd1, 1'b1, 32'h0000_1002, 32'h0, 5'd4, 0, 1, 1'b0);
    access(1'b0, 2'd0, 1'b0, 32'h0000_1001, 32'h0, 5'd5, 0, 1, 1'b0);
    access(1'b0, 2'd1, 1'b0, 32'h0000_1000, 32'h0, 5'd6, 0, 1, 1'b0);
    access(1'b0, 2'd3, 1'b1, 32'h0000_1004, 32'h0, 5'd8, 0, 1, 1'b0);
    // Stores: byte, half, word.
    access(1'b1, 2'd0, 1'b0, 32'h0000_2001, 32'h0000_00AB, 5'd9, 1, 1, 1'b0);
    access(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h1234_CDEF, 5'd10, 0, 1, 1'b0);
    access(1'b1, 2'd2, 1'b0, 32'h0000_2004, 32'hCAFE_F00D, 5'd11, 3, 1, 1'b0);
    // Misaligned half load then word store.
    access(1'b0, 2'd1, 1'b0, 32'h0000_3001, 32'h0, 5'd12, 0, 1, 1'b0);
    access(1'b1, 2'd2, 1'b0, 32'h0000_3002, 32'h1111_2222, 5'd13, 0, 1, 1'b0);
    // Ack held for three cycles completes once.
    access(1'b0, 2'd2, 1'b0, 32'h0000_1008, 32'h0, 5'd14, 1, 3, 1'b0);

    // Reset while waiting in ISSUE, then a stray ack.
    while (e < free_e) @(negedge clk);
    a = e + 1;
    x_ready[a] = 1'b0; x_ready[a+1] = 1'b0;
    for (int i = a; i <= a + 1; i++) begin
      x_mreq[i] = 1'b1; x_we[i] = 1'b0;
      x_addr[i] = 32'h0000_1004; x_be[i] = 4'hF;
    end
    bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_size = 2'd2;
    bus.req_unsigned = 1'b0; bus.addr = 32'h0000_1004; bus.req_rd = 5'd15;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset();
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    free_e = e;

    // Back-to-back loads, req_valid held, zero-wait memory.
    access(1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0, 5'd0, 0, 1, 1'b1);
    access(1'b0, 2'd0, 1'b0, 32'h0000_1006, 32'h0, 5'd16, 0, 1, 1'b1);
    access(1'b0, 2'd1, 1'b1, 32'h0000_100A, 32'h0, 5'd17, 0, 1, 1'b1);
    access(1'b0, 2'd2, 1'b0, 32'h0000_100C, 32'h0, 5'd18, 0, 1, 1'b1);
    access(1'b0, 2'd0, 1'b1, 32'h0000_1009, 32'h0, 5'd19, 0, 1, 1'b0);

    while (e < free_e + 2) @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
